text_bus_if: RTL



---
 rtl/text_mode_pkg.sv | 38 +++
 rtl/bus_sync.sv | 30 +++
 rtl/text_bus_if.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/text_mode_pkg.sv
// rtl/text_mode_pkg.sv - shared constants and types for the text-mode bus front end
// Purpose: screen geometry, register map indices, command codes, reset values,
//          main FSM state encoding and a cursor range helper.
package text_mode_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 25;
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_DATA   = 4'd1;
  localparam logic [3:0] REG_CUR_LO = 4'd2;
  localparam logic [3:0] REG_CUR_HI = 4'd3;
  localparam logic [3:0] REG_CMD    = 4'd4;
  localparam logic [3:0] REG_FILL   = 4'd5;
  localparam logic [3:0] REG_STATUS = 4'd6;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] FILL_RST  = 8'h20;
  localparam logic [7:0] CTRL_RST  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FETCH,
    ST_LATCH,
    ST_CLEAR
  } state_e;

  // Cursor positions past the last cell collapse to the home position.
  function automatic logic [ADDR_W-1:0] cursor_clamp(input logic [ADDR_W-1:0] c);
    return (c > LAST_CELL) ? '0 : c;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - synchroniser and falling-edge detector for the bus strobe
// Purpose: bring the asynchronous bus strobe into clk and flag its falling edge.
// Ports:   clk, rst_n   - system clock, async active-low reset
//          strobe_i     - asynchronous strobe (clk_ext1 gated by chip select)
//          fall_o       - high for one clk when the synchronised strobe falls
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign fall_o = last_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/text_bus_if.sv
// rtl/text_bus_if.sv - CPU bus front end for the 80x25 text-mode display
// Purpose: control registers, auto-incrementing cursor, screen RAM write port,
//          cursor-cell prefetch for CPU reads and a hardware clear-screen fill.
// Ports:   clk, rst_n                     - system clock, async active-low reset
//          clk_ext1_i, cs_i, rs_i, wren_i - asynchronous CPU bus cycle
//          data_in_i / data_out_o / data_oe_o - bus data and drive enable
//          ram_waddr_o, ram_wdata_o, ram_we_o - screen RAM write port
//          ram_raddr_o, ram_rdata_i       - CPU-side read port (1 clk latency)
//          enable_o, busy_o               - display enable, clear in progress
module text_bus_if
  import text_mode_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_ext1_i,
  input  logic              cs_i,
  input  logic [3:0]        rs_i,
  input  logic              wren_i,
  input  logic [7:0]        data_in_i,
  output logic [7:0]        data_out_o,
  output logic              data_oe_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [7:0]        ram_wdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              enable_o,
  output logic              busy_o
);

  logic              commit;
  logic              wr;
  state_e            state_q;
  logic [7:0]        ctrl_q;
  logic [7:0]        fill_q;
  logic [7:0]        prefetch_q;
  logic [ADDR_W-1:0] cursor_q;
  logic [ADDR_W-1:0] cursor_wr_d;
  logic [ADDR_W-1:0] cursor_inc_d;

  bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (clk_ext1_i & ~cs_i),
    .fall_o   (commit)
  );

  // rs/wren/data_in are still held stable by the bus on the commit edge.
  assign wr        = commit & ~wren_i;
  assign data_oe_o = clk_ext1_i & ~cs_i & wren_i;
  assign enable_o  = ctrl_q[0];

  always_comb begin
    cursor_wr_d = cursor_q;
    if (rs_i == REG_CUR_LO) begin
      cursor_wr_d = {cursor_q[ADDR_W-1:8], data_in_i};
    end else if (rs_i == REG_CUR_HI) begin
      cursor_wr_d = {data_in_i[ADDR_W-9:0], cursor_q[7:0]};
    end
    cursor_wr_d = cursor_clamp(cursor_wr_d);
  end

  assign cursor_inc_d = (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDR_W'(1);

  always_comb begin
    data_out_o = 8'h00;
    case (rs_i)
      REG_CTRL:   data_out_o = ctrl_q;
      REG_DATA:   data_out_o = prefetch_q;
      REG_CUR_LO: data_out_o = cursor_q[7:0];
      REG_CUR_HI: data_out_o = 8'(cursor_q[ADDR_W-1:8]);
      REG_FILL:   data_out_o = fill_q;
      REG_STATUS: data_out_o = {7'd0, busy_o};
      default:    data_out_o = 8'h00;
    endcase
  end

  // CTRL and FILL are accepted even during a clear; FILL is only sampled
  // when the next clear starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_RST;
      fill_q <= FILL_RST;
    end else if (wr) begin
      if (rs_i == REG_CTRL) ctrl_q <= data_in_i;
      if (rs_i == REG_FILL) fill_q <= data_in_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cursor_q    <= '0;
      prefetch_q  <= 8'h00;
      ram_we_o    <= 1'b0;
      ram_waddr_o <= '0;
      ram_wdata_o <= 8'h00;
      ram_raddr_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state_q)
        ST_WRITE: begin
          ram_we_o <= 1'b0;
          state_q  <= ST_FETCH;
          if (ctrl_q[1]) begin
            cursor_q    <= cursor_inc_d;
            ram_raddr_o <= cursor_inc_d;
          end else begin
            ram_raddr_o <= cursor_q;
          end
        end
        ST_FETCH: state_q <= ST_LATCH;
        ST_CLEAR: begin
          if (ram_waddr_o == LAST_CELL) begin
            ram_we_o    <= 1'b0;
            busy_o      <= 1'b0;
            cursor_q    <= '0;
            ram_raddr_o <= '0;
            state_q     <= ST_FETCH;
          end else begin
            ram_waddr_o <= ram_waddr_o + ADDR_W'(1);
          end
        end
        default: begin
          // IDLE, and LATCH which may overlap a back-to-back bus commit.
          if (state_q == ST_LATCH) prefetch_q <= ram_rdata_i;
          state_q <= ST_IDLE;
          if (wr) begin
            if (rs_i == REG_DATA) begin
              state_q     <= ST_WRITE;
              ram_we_o    <= 1'b1;
              ram_waddr_o <= cursor_q;
              ram_wdata_o <= data_in_i;
            end else if (rs_i == REG_CUR_LO || rs_i == REG_CUR_HI) begin
              cursor_q    <= cursor_wr_d;
              ram_raddr_o <= cursor_wr_d;
              state_q     <= ST_FETCH;
            end else if (rs_i == REG_CMD && data_in_i == CMD_CLEAR) begin
              state_q     <= ST_CLEAR;
              busy_o      <= 1'b1;
              ram_we_o    <= 1'b1;
              ram_waddr_o <= '0;
              ram_wdata_o <= fill_q;
            end
          end
        end
      endcase
    end
  end

endmodule
